// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, key-code table and row-drive constants for keypad_scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    LATCH        = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam int STATUS_VALID_BIT = 0;
  localparam int STATUS_OVR_BIT   = 1;

  localparam logic [3:0] COL_IDLE = 4'hF;

  // Active-low one-hot row drive, indexed by row number.
  localparam logic [3:0][3:0] ROW_DRIVE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // Indexed by {row, col}; entry 0 is row0/col0.
  localparam logic [15:0][3:0] KEY_TABLE = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  // Lowest-index low column wins when several are pressed.
  function automatic logic [1:0] lowest_col(input logic [3:0] pattern);
    logic [1:0] col;
    col = 2'd0;
    if (!pattern[0])      col = 2'd0;
    else if (!pattern[1]) col = 2'd1;
    else if (!pattern[2]) col = 2'd2;
    else if (!pattern[3]) col = 2'd3;
    return col;
  endfunction

endpackage

// File: rtl/keypad_debouncer.sv
// rtl/keypad_debouncer.sv - asserts done when sample has equalled target for N consecutive enabled cycles
module keypad_debouncer #(
  parameter int N = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] sample,
  input  logic [3:0] target,
  output logic       match,
  output logic       done
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] cnt;

  always_comb begin
    match = (sample == target);
    done  = enable && match && (cnt == W'(N - 1));
  end

  // Counter restarts whenever idle, on any mismatch, or once done is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!enable || !match || done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scan, debounce and encode with CPU status/data readout
// Optional overrun status bit enabled by defining KEYPAD_OVERRUN_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] rowwrite,
  input  logic [3:0] colread,
  input  logic       ack,
  input  logic       statusordata,
  output logic [3:0] keyout
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [3:0]    col_meta;
  logic [3:0]    col_s;
  state_t        state;
  state_t        state_n;
  logic [1:0]    row_idx;
  logic [1:0]    row_n;
  logic [SW-1:0] scan_cnt;
  logic [SW-1:0] scan_n;
  logic [3:0]    cap;
  logic [3:0]    cap_n;
  logic          db_en;
  logic [3:0]    db_target;
  logic          db_match;
  logic          db_done;
  logic          store;
  logic [3:0]    key_code;
  logic          valid;
  logic          ovr;
  logic [3:0]    status;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta <= COL_IDLE;
      col_s    <= COL_IDLE;
    end else begin
      col_meta <= colread;
      col_s    <= col_meta;
    end
  end

  keypad_debouncer #(.N(DEBOUNCE_CNT)) u_debouncer (
    .clk    (clk),
    .rst    (rst),
    .enable (db_en),
    .sample (col_s),
    .target (db_target),
    .match  (db_match),
    .done   (db_done)
  );

  always_comb begin
    state_n   = state;
    row_n     = row_idx;
    scan_n    = scan_cnt;
    cap_n     = cap;
    db_en     = 1'b0;
    db_target = COL_IDLE;
    store     = 1'b0;
    case (state)
      SCAN: begin
        if (scan_cnt == SCAN_LAST) begin
          scan_n = '0;
          if (col_s != COL_IDLE) begin
            cap_n   = col_s;
            state_n = DEBOUNCE;
          end else begin
            row_n = row_idx + 2'd1;
          end
        end else begin
          scan_n = scan_cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        db_en     = 1'b1;
        db_target = cap;
        if (!db_match) begin
          state_n = SCAN;
          row_n   = row_idx + 2'd1;
        end else if (db_done) begin
          state_n = LATCH;
        end
      end
      LATCH: begin
        store   = !valid || ack;
        state_n = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        db_en     = 1'b1;
        db_target = COL_IDLE;
        if (db_done) begin
          state_n = SCAN;
          row_n   = row_idx + 2'd1;
        end
      end
      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SCAN;
      row_idx  <= 2'd0;
      scan_cnt <= '0;
      cap      <= COL_IDLE;
    end else begin
      state    <= state_n;
      row_idx  <= row_n;
      scan_cnt <= scan_n;
      cap      <= cap_n;
    end
  end

  // A store in the same cycle as ack wins, so valid stays set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code <= 4'h0;
      valid    <= 1'b0;
    end else if (store) begin
      key_code <= KEY_TABLE[{row_idx, lowest_col(cap)}];
      valid    <= 1'b1;
    end else if (ack) begin
      valid <= 1'b0;
    end
  end

`ifdef KEYPAD_OVERRUN_EN
  logic drop;
  assign drop = (state == LATCH) && valid && !ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr <= 1'b0;
    end else if (drop) begin
      ovr <= 1'b1;
    end else if (ack) begin
      ovr <= 1'b0;
    end
  end
`else
  assign ovr = 1'b0;
`endif

  assign rowwrite = ROW_DRIVE[row_idx];

  always_comb begin
    status                   = 4'h0;
    status[STATUS_VALID_BIT] = valid;
    status[STATUS_OVR_BIT]   = ovr;
    keyout = statusordata ? key_code : status;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=8)
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ack = 1'b0;
  logic       sod = 1'b0;
  logic [3:0] colread;
  logic [3:0] rowwrite;
  logic [3:0] keyout;

  logic       press_en  = 1'b0;
  logic [1:0] press_row = 2'd0;
  logic [1:0] press_col = 2'd0;

  int n_asserts = 0;
  int n_fails   = 0;

`ifdef KEYPAD_OVERRUN_EN
  localparam logic [3:0] OVR_STATUS = 4'b0011;
`else
  localparam logic [3:0] OVR_STATUS = 4'b0001;
`endif

  always #5 clk = ~clk;

  // Matrix model: a pressed key pulls its column low only while its row is driven.
  always_comb begin
    colread = 4'hF;
    if (press_en && !rowwrite[press_row]) colread[press_col] = 1'b0;
  end

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .rowwrite     (rowwrite),
    .colread      (colread),
    .ack          (ack),
    .statusordata (sod),
    .keyout       (keyout)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic s, output logic [3:0] v);
    sod = s;
    #1;
    v = keyout;
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c);
    press_row = r;
    press_col = c;
    press_en  = 1'b1;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    step(1);
    ack = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output logic ok);
    logic [3:0] v;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      step(1);
      rd(1'b0, v);
      if (v[0]) ok = 1'b1;
    end
  endtask

  initial begin
    logic [3:0] v;
    logic [3:0] seen;
    logic       any_valid;
    logic       ok;

    // Reset state
    step(3);
    rd(1'b0, v); check("reset_status", v, 4'h0);
    rd(1'b1, v); check("reset_data", v, 4'h0);
    check("reset_row", rowwrite, 4'b1110);
    rst = 1'b0;
    step(3);
    check("dwell_row0", rowwrite, 4'b1110);
    step(1);
    check("dwell_row1", rowwrite, 4'b1101);

    // Key 6: latch, read, ack, no auto-repeat
    press(2'd1, 2'd2);
    step(40);
    rd(1'b0, v); check("key6_status", v, 4'b0001);
    rd(1'b1, v); check("key6_data", v, 4'h6);
    rd(1'b0, v); check("key6_data_keeps_valid", v, 4'b0001);
    pulse_ack();
    rd(1'b0, v); check("key6_ack_status", v, 4'b0000);
    step(40);
    rd(1'b0, v); check("key6_no_repeat", v, 4'b0000);
    press_en = 1'b0;
    step(30);
    rd(1'b0, v); check("key6_release", v, 4'b0000);

    // Bounce on row2/col0: 5 low, 1 high
    seen      = 4'h0;
    any_valid = 1'b0;
    press_row = 2'd2;
    press_col = 2'd0;
    for (int i = 0; i < 120; i++) begin
      press_en = ((i % 6) < 5);
      step(1);
      seen = seen | ~rowwrite;
      rd(1'b0, v);
      if (v[0]) any_valid = 1'b1;
    end
    press_en = 1'b0;
    check("bounce_no_valid", {3'b000, any_valid}, 4'h0);
    check("bounce_rows_rotate", seen, 4'hF);
    step(20);

    // Key 5 then key 9 without ack
    press(2'd1, 2'd1);
    step(40);
    press_en = 1'b0;
    step(30);
    rd(1'b0, v); check("key5_status", v, 4'b0001);
    rd(1'b1, v); check("key5_data", v, 4'h5);
    press(2'd2, 2'd2);
    step(40);
    press_en = 1'b0;
    step(30);
    rd(1'b1, v); check("key9_dropped_data", v, 4'h5);
    rd(1'b0, v); check("key9_overrun_status", v, OVR_STATUS);
    pulse_ack();
    rd(1'b0, v); check("overrun_ack_status", v, 4'b0000);
    rd(1'b1, v); check("overrun_ack_data", v, 4'h5);

    // Key A latched while ack is high in the same cycle
    ack = 1'b1;
    press(2'd0, 2'd3);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step(1);
      rd(1'b1, v);
      if (v == 4'hA) ok = 1'b1;
    end
    ack = 1'b0;
    check("keyA_latched", {3'b000, ok}, 4'h1);
    rd(1'b0, v); check("keyA_status", v, 4'b0001);
    rd(1'b1, v); check("keyA_data", v, 4'hA);
    press_en = 1'b0;
    step(30);
    pulse_ack();
    rd(1'b0, v); check("keyA_ack_status", v, 4'b0000);

    // Reset during WAIT_RELEASE with key 3 held
    press(2'd0, 2'd2);
    wait_valid(100, ok);
    check("key3_first_valid", {3'b000, ok}, 4'h1);
    step(3);
    rst = 1'b1;
    #1;
    check("midhold_rst_row", rowwrite, 4'b1110);
    rd(1'b0, v); check("midhold_rst_status", v, 4'h0);
    rd(1'b1, v); check("midhold_rst_data", v, 4'h0);
    step(2);
    rst = 1'b0;
    wait_valid(100, ok);
    check("key3_relatch_valid", {3'b000, ok}, 4'h1);
    rd(1'b1, v); check("key3_relatch_data", v, 4'h3);
    pulse_ack();
    step(40);
    rd(1'b0, v); check("key3_once", v, 4'b0000);
    press_en = 1'b0;
    step(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
